// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } arb_state_e;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int NUM_REQ_DEF    = 4;

  // Width of a requester index; at least one bit so a single-requester build still elaborates.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester at or after rr_ptr_i wins.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic [IDW-1:0]     winner_o,
  output logic               any_req_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (!any_req_o && req_i[idx]) begin
        winner_o  = idx;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with overflow retry.
// Define FIFO_WR_ARB_AF_THROTTLE_EN to also hold off writes while fifo_almostfull is high.
//
// Handshake: a requester raises req_valid[i] and holds it until it sees a one-cycle
// req_ack[i] or req_err[i]; req_data is latched in the grant cycle, so it only needs to be
// valid then. fifo_wr_ack / fifo_overflow are only looked at the cycle after fifo_wr_en.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int MAX_RETRY  = 3,
  localparam int IDW       = id_width(NUM_REQ),
  localparam int RCW       = $clog2(MAX_RETRY + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          busy,
  output logic [IDW-1:0]                grant_id,
  output arb_state_e                    dbg_state_o,
  output logic [RCW-1:0]                dbg_retry_o
);

  arb_state_e             state_q, state_d;
  logic [FIFO_WIDTH-1:0]  data_q, data_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [RCW-1:0]         retry_cnt_q, retry_cnt_d;
  logic                   ok_q, ok_d;

  logic [FIFO_WIDTH-1:0]  req_words [NUM_REQ];
  logic [IDW-1:0]         winner;
  logic                   any_req;
  logic                   has_space;
  logic                   wr_failed;
  logic [RCW-1:0]         retry_inc;
  logic [NUM_REQ-1:0]     owner_onehot;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_words[i] = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
  assign has_space = !fifo_full && !fifo_almostfull;
`else
  assign has_space = !fifo_full;
`endif

  // Overflow dominates a simultaneous ack; silence is also a failed attempt.
  assign wr_failed = fifo_overflow || !fifo_wr_ack;
  assign retry_inc = retry_cnt_q + RCW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      retry_cnt_q <= '0;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      retry_cnt_q <= retry_cnt_d;
      ok_q        <= ok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    retry_cnt_d = retry_cnt_q;
    ok_d        = ok_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          data_d      = req_words[winner];
          grant_d     = winner;
          retry_cnt_d = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (has_space) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!wr_failed) begin
          ok_d    = 1'b1;
          state_d = DONE;
        end else begin
          retry_cnt_d = retry_inc;
          if (retry_inc == RCW'(MAX_RETRY)) begin
            ok_d    = 1'b0;
            state_d = DONE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      DONE: begin
        rr_ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign req_ack      = (state_q == DONE && ok_q)  ? owner_onehot : '0;
  assign req_err      = (state_q == DONE && !ok_q) ? owner_onehot : '0;
  assign fifo_wr_en   = (state_q == ISSUE);
  assign fifo_data_in = data_q;
  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_q;
  assign dbg_state_o  = state_q;
  assign dbg_retry_o  = retry_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: scenario tasks plus a randomized run against a round-robin model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int MR  = 3;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   req_err;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_wr_en;
  logic           fifo_full;
  logic           fifo_almostfull;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic           busy;
  logic [IDW-1:0] grant_id;
  arb_state_e     dbg_state;
  logic [1:0]     dbg_retry;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;
  int wr_cnt   = 0;
  int ovf_left = 0;
  bit silent   = 0;
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_RETRY(MR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ack         (req_ack),
    .req_err         (req_err),
    .fifo_data_in    (fifo_data_in),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .busy            (busy),
    .grant_id        (grant_id),
    .dbg_state_o     (dbg_state),
    .dbg_retry_o     (dbg_retry)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // FIFO write-side model: records each write, answers the next cycle.
  initial begin
    fifo_wr_ack   = 1'b0;
    fifo_overflow = 1'b0;
    forever begin
      @(posedge clk); #1;
      fifo_wr_ack   = 1'b0;
      fifo_overflow = 1'b0;
      if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
        wr_cnt++;
        got_q.push_back(fifo_data_in);
        @(posedge clk); #1;
        if (!silent) begin
          if (ovf_left > 0) begin
            ovf_left--;
            fifo_overflow = 1'b1;
          end else begin
            fifo_wr_ack = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] w);
    req_data[i*W +: W] = w;
  endtask

  task automatic wait_done(output int cyc, output logic [N-1:0] ack_v, output logic [N-1:0] err_v);
    cyc   = 0;
    ack_v = '0;
    err_v = '0;
    while (cyc < 100) begin
      step();
      cyc++;
      if ((req_ack | req_err) !== '0) begin
        ack_v = req_ack;
        err_v = req_err;
        break;
      end
    end
  endtask

  // Reference arbitration: first requesting index scanning upward from ptr with wrap.
  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    m_ptr = 0;
    got_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W+2*N+2+IDW-1:0] outs;
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    fifo_full = 1'b0; fifo_almostfull = 1'b0;
    #3;
    outs = {fifo_wr_en, fifo_data_in, req_ack, req_err, busy, grant_id};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_outputs: got %0h expected 0", outs);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    m_ptr = 0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_single();
    set_word(2, 16'hBEEF);
    req_valid = 4'b0100;
    step();
    checks++;
    if (grant_id !== IDW'(rr_pick(req_valid, m_ptr)) || busy !== 1'b1 || fifo_wr_en !== 1'b0) begin
      failures++; $display("FAIL single_c1: grant=%0d busy=%0b wr_en=%0b expected grant 2 busy 1 wr_en 0", grant_id, busy, fifo_wr_en);
    end
    step();
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'hBEEF) begin
      failures++; $display("FAIL single_c2_write: wr_en=%0b data=%0h expected 1 beef", fifo_wr_en, fifo_data_in);
    end
    step();
    checks++;
    if (fifo_wr_en !== 1'b0) begin
      failures++; $display("FAIL single_c3_one_write: wr_en=%0b expected 0", fifo_wr_en);
    end
    step();
    checks++;
    if (req_ack !== 4'b0100 || req_err !== 4'b0000) begin
      failures++; $display("FAIL single_c4_ack: ack=%0b err=%0b expected 0100 0000", req_ack, req_err);
    end
    req_valid = '0;
    m_ptr = 3;
    step();
    checks++;
    if (busy !== 1'b0 || req_ack !== '0) begin
      failures++; $display("FAIL single_c5_idle: busy=%0b ack=%0b expected 0 0", busy, req_ack);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'hBEEF) begin
      failures++; $display("FAIL single_fifo_words: count=%0d expected 1 word beef", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] ack_v, err_v;
    logic [W-1:0] words [N];
    int cyc, win;
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      words[i] = W'($urandom);
      set_word(i, words[i]);
    end
    req_valid = '1;
    for (int t = 0; t < 5; t++) begin
      win = rr_pick(req_valid, m_ptr);
      exp_q.push_back(words[win]);
      wait_done(cyc, ack_v, err_v);
      checks++;
      if (ack_v !== N'(1 << win) || err_v !== '0) begin
        failures++; $display("FAIL rr_order[%0d]: ack=%0b err=%0b expected ack %0b", t, ack_v, err_v, N'(1 << win));
      end
      checks++;
      if (cyc != ((t == 0) ? 4 : 5)) begin
        failures++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected %0d", t, cyc, (t == 0) ? 4 : 5);
      end
      checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
        failures++; $display("FAIL rr_data[%0d]: got %0h (count %0d) expected %0h", t,
                             (got_q.size() > 0) ? got_q[0] : 'x, got_q.size(), exp_q[0]);
      end
      got_q.delete();
      void'(exp_q.pop_front());
      m_ptr = (win + 1) % N;
      words[win] = W'($urandom);
      set_word(win, words[win]);
      if (t == 4) req_valid = '0;
    end
    step();
  endtask

  task automatic test_full_stall();
    logic [N-1:0] ack_v, err_v;
    logic [W-1:0] w;
    int r, cyc;
    bit bad;
    r = $urandom_range(0, N-1);
    w = W'($urandom);
    set_word(r, w);
    fifo_full = 1'b1;
    req_valid = N'(1 << r);
    step();
    checks++;
    if (grant_id !== IDW'(rr_pick(req_valid, m_ptr))) begin
      failures++; $display("FAIL stall_grant: got %0d expected %0d", grant_id, r);
    end
    bad = 1'b0;
    repeat (10) begin
      step();
      if (fifo_wr_en !== 1'b0 || dbg_state !== HOLD) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL stall_hold: wr_en=%0b state=%0d expected 0 and HOLD for 10 cycles", fifo_wr_en, dbg_state);
    end
    fifo_full = 1'b0;
    step();
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_data_in !== w || dbg_retry !== 2'd0) begin
      failures++; $display("FAIL stall_release: wr_en=%0b data=%0h retry=%0d expected 1 %0h 0", fifo_wr_en, fifo_data_in, dbg_retry, w);
    end
    wait_done(cyc, ack_v, err_v);
    checks++;
    if (ack_v !== N'(1 << r) || err_v !== '0 || cyc != 2) begin
      failures++; $display("FAIL stall_ack: ack=%0b err=%0b after %0d cycles expected %0b after 2", ack_v, err_v, cyc, N'(1 << r));
    end
    req_valid = '0;
    m_ptr = (r + 1) % N;
    got_q.delete();
    step();
  endtask

  task automatic test_overflow();
    logic [N-1:0] ack_v, err_v;
    logic [W-1:0] w;
    int r, cyc, wr0, win;
    bit bad;
    for (int mode = 0; mode < 2; mode++) begin
      silent   = (mode == 1);
      ovf_left = (mode == 0) ? 1000 : 0;
      r = $urandom_range(0, N-1);
      w = W'($urandom);
      set_word(r, w);
      wr0 = wr_cnt;
      req_valid = N'(1 << r);
      wait_done(cyc, ack_v, err_v);
      checks++;
      if (err_v !== N'(1 << r) || ack_v !== '0) begin
        failures++; $display("FAIL ovf_err[%0d]: err=%0b ack=%0b expected err %0b ack 0", mode, err_v, ack_v, N'(1 << r));
      end
      checks++;
      if (wr_cnt - wr0 != MR) begin
        failures++; $display("FAIL ovf_attempts[%0d]: got %0d writes expected %0d", mode, wr_cnt - wr0, MR);
      end
      bad = 1'b0;
      foreach (got_q[i]) if (got_q[i] !== w) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++; $display("FAIL ovf_retry_data[%0d]: a retried word differed from %0h", mode, w);
      end
      got_q.delete();
      silent = 1'b0;
      ovf_left = 0;
      m_ptr = (r + 1) % N;
      req_valid = '1;
      step();
      step();
      win = rr_pick(req_valid, m_ptr);
      checks++;
      if (grant_id !== IDW'(win)) begin
        failures++; $display("FAIL ovf_ptr_advance[%0d]: grant %0d expected %0d", mode, grant_id, win);
      end
      wait_done(cyc, ack_v, err_v);
      checks++;
      if (ack_v !== N'(1 << win)) begin
        failures++; $display("FAIL ovf_followup_ack[%0d]: ack=%0b expected %0b", mode, ack_v, N'(1 << win));
      end
      req_valid = '0;
      m_ptr = (win + 1) % N;
      got_q.delete();
      step();
    end
  endtask

  task automatic test_af_throttle();
    logic [N-1:0] ack_v, err_v;
    int r, cyc;
    r = $urandom_range(0, N-1);
    set_word(r, W'($urandom));
    fifo_almostfull = 1'b1;
    req_valid = N'(1 << r);
    step();
    step();
`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
    begin
      bit bad;
      bad = (fifo_wr_en !== 1'b0);
      repeat (4) begin
        step();
        if (fifo_wr_en !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        failures++; $display("FAIL af_throttle_hold: write issued while almostfull");
      end
      fifo_almostfull = 1'b0;
      step();
      checks++;
      if (fifo_wr_en !== 1'b1) begin
        failures++; $display("FAIL af_throttle_release: wr_en=%0b expected 1", fifo_wr_en);
      end
    end
`else
    checks++;
    if (fifo_wr_en !== 1'b1) begin
      failures++; $display("FAIL af_ignored: wr_en=%0b at c2 expected 1", fifo_wr_en);
    end
`endif
    wait_done(cyc, ack_v, err_v);
    checks++;
    if (ack_v !== N'(1 << r) || err_v !== '0) begin
      failures++; $display("FAIL af_ack: ack=%0b err=%0b expected %0b", ack_v, err_v, N'(1 << r));
    end
    fifo_almostfull = 1'b0;
    req_valid = '0;
    m_ptr = (r + 1) % N;
    got_q.delete();
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] ack_v, err_v, mask, add;
    logic [W-1:0] words [N];
    int cyc, win, wr0, budget, exp_wr;
    bit bad;
    mask = '0;
    while (mask == '0) mask = N'($urandom_range(0, (1 << N) - 1));
    for (int i = 0; i < N; i++) begin
      words[i] = W'($urandom);
      set_word(i, words[i]);
    end
    budget = $urandom_range(0, MR);
    ovf_left = budget;
    req_valid = mask;
    for (int t = 0; t < 24; t++) begin
      win = rr_pick(mask, m_ptr);
      exp_wr = (budget < MR) ? budget + 1 : MR;
      exp_q.push_back(words[win]);
      wr0 = wr_cnt;
      wait_done(cyc, ack_v, err_v);
      checks++;
      if ((budget < MR  && (ack_v !== N'(1 << win) || err_v !== '0)) ||
          (budget >= MR && (err_v !== N'(1 << win) || ack_v !== '0))) begin
        failures++; $display("FAIL rand_outcome[%0d]: ack=%0b err=%0b expected owner %0d overflows %0d", t, ack_v, err_v, win, budget);
      end
      checks++;
      if (wr_cnt - wr0 != exp_wr) begin
        failures++; $display("FAIL rand_writes[%0d]: got %0d expected %0d", t, wr_cnt - wr0, exp_wr);
      end
      bad = (got_q.size() == 0);
      foreach (got_q[i]) if (got_q[i] !== exp_q[0]) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++; $display("FAIL rand_data[%0d]: written word differs from %0h", t, exp_q[0]);
      end
      got_q.delete();
      void'(exp_q.pop_front());
      m_ptr = (win + 1) % N;
      mask[win] = 1'b0;
      add = N'($urandom_range(0, (1 << N) - 1)) & ~mask;
      if (t != 23 && (mask | add) == '0) add = N'(1 << $urandom_range(0, N-1));
      if (t == 23) add = '0;
      for (int i = 0; i < N; i++) begin
        if (add[i]) begin
          words[i] = W'($urandom);
          set_word(i, words[i]);
        end
      end
      mask = mask | add;
      if (t == 23) mask = '0;
      budget = $urandom_range(0, MR);
      ovf_left = budget;
      req_valid = mask;
    end
    ovf_left = 0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] ack_v, err_v;
    logic [W+2*N+2+IDW-1:0] outs;
    int cyc;
    bit bad;
    set_word(1, W'($urandom));
    req_valid = 4'b0010;
    wait_done(cyc, ack_v, err_v);
    req_valid = '0;
    m_ptr = 2;
    step();
    got_q.delete();
    set_word(2, W'($urandom));
    req_valid = 4'b0100;
    step();
    step();
    step();
    checks++;
    if (dbg_state !== WAIT) begin
      failures++; $display("FAIL rstmid_reach_wait: state=%0d expected %0d", dbg_state, WAIT);
    end
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    outs = {fifo_wr_en, fifo_data_in, req_ack, req_err, busy, grant_id};
    checks++;
    if (outs !== '0 || dbg_state !== IDLE) begin
      failures++; $display("FAIL rstmid_async_clear: outputs=%0h state=%0d expected 0 IDLE", outs, dbg_state);
    end
    bad = 1'b0;
    repeat (3) begin
      step();
      if ((req_ack | req_err) !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL rstmid_no_pulse: ack or err seen during reset");
    end
    rst_n = 1'b1;
    m_ptr = 0;
    req_valid = '1;
    step();
    checks++;
    if (grant_id !== IDW'(rr_pick(req_valid, m_ptr)) || busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_first_grant: grant=%0d busy=%0b expected 0 1", grant_id, busy);
    end
    wait_done(cyc, ack_v, err_v);
    checks++;
    if (ack_v !== 4'b0001 || err_v !== '0) begin
      failures++; $display("FAIL rstmid_ack: ack=%0b err=%0b expected 0001 0000", ack_v, err_v);
    end
    req_valid = '0;
    got_q.delete();
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_overflow();
    test_af_throttle();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
